reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Sits directly downstream of the PLL clock generator, in the 25 MHz slow-clock domain. Consumes the PLL lock indication and produces staged, synchronous, active-high resets for the system: peripherals and Wishbone bus first, CPU core last. Re-enters reset on PLL lock loss or on a software reset request, and records the cause of the most recent reset.

## Interface

Parameters:
- `LOCK_STABLE_CYCLES`, default 1024: consecutive synchronized-lock cycles required before any reset is released. Must be ≥ 2.
- `CPU_DELAY_CYCLES`, default 16: cycles between peripheral release and CPU release. Must be ≥ 2.
- `SW_RESET_CYCLES`, default 64: length of a software-requested reset. Must be ≥ 2.

Ports (clock and reset first):
- `clk_in` input 1: slow system clock from the PLL, 25 MHz.
- `reset_n_in` input 1: asynchronous, active-low reset.
- `locked_in` input 1: PLL lock. Asynchronous to `clk_in`.
- `sw_reset_req_in` input 1: synchronous single-cycle request from the system control register.
- `periph_reset_out` output 1: active-high synchronous reset for the bus and peripherals.
- `cpu_reset_out` output 1: active-high synchronous reset for the CPU.
- `ready_out` output 1: high only in RUN.
- `reset_cause_out` output 2: cause of the most recent reset entry. 00 = external/power-on, 01 = lock loss, 10 = software.

## Operation

- `locked_in` passes through a 2-FF synchronizer to produce `lock_s`. No other logic samples `locked_in`.
- A single counter `cnt` is sized `$clog2` of the largest parameter. It is cleared on every state change.
- FSM states and transitions:
  - **WAIT_LOCK**
    - Resets: periph 1, cpu 1.
    - If `lock_s`=1: go to STABLE.
  - **STABLE**
    - Resets: periph 1, cpu 1. `cnt` increments each cycle.
    - If `lock_s`=0: go to WAIT_LOCK.
    - Else if `cnt`==LOCK_STABLE_CYCLES-1: go to PERIPH.
  - **PERIPH**
    - Resets: periph 0, cpu 1. `cnt` increments each cycle.
    - If `cnt`==CPU_DELAY_CYCLES-1: go to RUN.
  - **RUN**
    - Resets: periph 0, cpu 0. `ready_out`=1.
    - If `sw_reset_req_in`=1: go to SW_RESET and set cause to 10.
  - **SW_RESET**
    - Resets: periph 1, cpu 1. `cnt` increments each cycle.
    - If `cnt`==SW_RESET_CYCLES-1: go to PERIPH. This path skips STABLE because lock is already qualified.
- Lock loss:
  - `lock_s`=0 in STABLE, PERIPH, RUN or SW_RESET sends the FSM to WAIT_LOCK.
  - The cause is set to 01, except in STABLE, where the cause is unchanged.
  - Lock loss has priority over every other transition, including a simultaneous `sw_reset_req_in`.
- `sw_reset_req_in` is ignored outside RUN. Requests are not queued.
- `reset_cause_out` holds its value until the next cause update.

## Timing

- All outputs are registered and computed from next-state. They change on the same edge as the state register, with no combinational decode glitches.
- Asynchronous reset (`reset_n_in`=0), applied immediately:
  - State → WAIT_LOCK, `cnt` → 0, synchronizer → 0.
  - `periph_reset_out`=1, `cpu_reset_out`=1, `ready_out`=0, `reset_cause_out`=00.
- Deassertion of `reset_n_in` is assumed to be externally synchronized to `clk_in`.
- Release latency, counting edge 1 as the first edge sampling `locked_in`=1:
  - `lock_s`=1 after edge 2; STABLE after edge 3.
  - `periph_reset_out` falls after edge LOCK_STABLE_CYCLES+3.
  - `cpu_reset_out` falls and `ready_out` rises CPU_DELAY_CYCLES edges later.
- Lock loss latency: `locked_in` falling before edge 1 → both resets asserted and `ready_out`=0 after edge 3.
- Lock-glitch rule: a `lock_s` drop during STABLE restarts qualification from WAIT_LOCK. A glitch shorter than one clock may be missed by the synchronizer; that is acceptable.
- Software reset: request sampled in RUN at edge k →
  - Both resets 1 after edge k.
  - PERIPH after edge k+SW_RESET_CYCLES.
  - RUN after edge k+SW_RESET_CYCLES+CPU_DELAY_CYCLES.
- `reset_n_in` asserted mid-sequence aborts immediately to the reset values above.

## Test plan

Bench parameters: LOCK_STABLE_CYCLES=8, CPU_DELAY_CYCLES=4, SW_RESET_CYCLES=6.

- **Power-up.**
  - Stimulus: `reset_n_in` low then released, `locked_in` held 0 for 50 cycles.
  - Required: periph=1, cpu=1, ready=0, cause=00 throughout.
- **Lock release sequence.**
  - Stimulus: `locked_in` rises before edge 1.
  - Required: `periph_reset_out` falls after edge 11; `cpu_reset_out` falls and `ready_out` rises after edge 15; cause stays 00.
- **Lock glitch during qualification.**
  - Stimulus: `locked_in` low for 3 cycles at STABLE `cnt`=5.
  - Required: return to WAIT_LOCK; full 8-cycle qualification restarts; resets never released early.
- **Lock loss in RUN.**
  - Stimulus: `locked_in` falls before edge 1.
  - Required: both resets 1, ready 0 and cause 01 after edge 3; recovery follows the sequence timing above.
- **Software reset.**
  - Stimulus: 1-cycle `sw_reset_req_in` in RUN at edge k.
  - Required: resets 1 after edge k, cause 10; periph 0 after edge k+6; cpu 0 and ready 1 after edge k+10.
  - A second request during SW_RESET is ignored.
- **Simultaneous events.**
  - Stimulus: `sw_reset_req_in` on the same edge where `lock_s` first reads 0.
  - Required: WAIT_LOCK with cause 01.
  - Also: `reset_n_in` asserted during PERIPH → all outputs take their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/reset_sequencer.sv
// Staged reset release from PLL lock: peripherals first, CPU last.
// Re-enters reset on lock loss or software request and records the cause.
module reset_sequencer #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int CPU_DELAY_CYCLES   = 16,
  parameter int SW_RESET_CYCLES    = 64
) (
  input  logic       clk_in,
  input  logic       reset_n_in,
  input  logic       locked_in,
  input  logic       sw_reset_req_in,
  output logic       periph_reset_out,
  output logic       cpu_reset_out,
  output logic       ready_out,
  output logic [1:0] reset_cause_out
);

  localparam int MAXC = (LOCK_STABLE_CYCLES > CPU_DELAY_CYCLES)
    ? ((LOCK_STABLE_CYCLES > SW_RESET_CYCLES)
       ? LOCK_STABLE_CYCLES : SW_RESET_CYCLES)
    : ((CPU_DELAY_CYCLES > SW_RESET_CYCLES)
       ? CPU_DELAY_CYCLES : SW_RESET_CYCLES);
  localparam int CW = ($clog2(MAXC) < 1) ? 1 : $clog2(MAXC);

  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CPU_LAST  = CW'(CPU_DELAY_CYCLES - 1);
  localparam logic [CW-1:0] SW_LAST   = CW'(SW_RESET_CYCLES - 1);

  localparam logic [1:0] CAUSE_EXT  = 2'b00;
  localparam logic [1:0] CAUSE_LOCK = 2'b01;
  localparam logic [1:0] CAUSE_SW   = 2'b10;

  typedef enum logic [2:0] {
    WAIT_LOCK,
    STABLE,
    PERIPH,
    RUN,
    SW_RESET
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    cause_q, cause_d;
  logic          sync1_q, lock_s_q;
  logic          periph_q, periph_d;
  logic          cpu_q, cpu_d;
  logic          ready_q, ready_d;

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= locked_in;
      lock_s_q <= sync1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    unique case (state_q)
      WAIT_LOCK: begin
        if (lock_s_q) state_d = STABLE;
      end
      STABLE: begin
        cnt_d = cnt_q + 1'b1;
        if (!lock_s_q) state_d = WAIT_LOCK;
        else if (cnt_q == LOCK_LAST) state_d = PERIPH;
      end
      PERIPH: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CPU_LAST) state_d = RUN;
      end
      RUN: begin
        if (sw_reset_req_in) begin
          state_d = SW_RESET;
          cause_d = CAUSE_SW;
        end
      end
      SW_RESET: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SW_LAST) state_d = PERIPH;
      end
      default: state_d = WAIT_LOCK;
    endcase
    // Lock loss overrides every other transition
    if (!lock_s_q && state_q != WAIT_LOCK) begin
      state_d = WAIT_LOCK;
      if (state_q != STABLE) cause_d = CAUSE_LOCK;
    end
    if (state_d != state_q) cnt_d = '0;
  end

  always_comb begin
    periph_d = 1'b1;
    cpu_d    = 1'b1;
    ready_d  = 1'b0;
    unique case (1'b1)
      state_d == PERIPH: periph_d = 1'b0;
      state_d == RUN: begin
        periph_d = 1'b0;
        cpu_d    = 1'b0;
        ready_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q  <= WAIT_LOCK;
      cnt_q    <= '0;
      cause_q  <= CAUSE_EXT;
      periph_q <= 1'b1;
      cpu_q    <= 1'b1;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cause_q  <= cause_d;
      periph_q <= periph_d;
      cpu_q    <= cpu_d;
      ready_q  <= ready_d;
    end
  end

  assign periph_reset_out = periph_q;
  assign cpu_reset_out    = cpu_q;
  assign ready_out        = ready_q;
  assign reset_cause_out  = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with short sequencing parameters.
// Per-cycle vector table plus hand sequences for async reset behaviour.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       locked;
  logic       sw_req;
  logic       periph;
  logic       cpu;
  logic       ready;
  logic [1:0] cause;

  int n_cmp = 0;
  int n_bad = 0;

  reset_sequencer #(
    .LOCK_STABLE_CYCLES(8),
    .CPU_DELAY_CYCLES(4),
    .SW_RESET_CYCLES(6)
  ) dut (
    .clk_in(clk),
    .reset_n_in(rst_n),
    .locked_in(locked),
    .sw_reset_req_in(sw_req),
    .periph_reset_out(periph),
    .cpu_reset_out(cpu),
    .ready_out(ready),
    .reset_cause_out(cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       lk;
    logic       sw;
    logic       p;
    logic       c;
    logic       r;
    logic [1:0] cs;
  } vec_t;

  vec_t vq[$];

  function automatic void add(logic lk, logic sw, logic p, logic c,
                              logic r, logic [1:0] cs, int n);
    vec_t v;
    v.lk = lk; v.sw = sw; v.p = p; v.c = c; v.r = r; v.cs = cs;
    for (int i = 0; i < n; i++) vq.push_back(v);
  endfunction

  task automatic check(string name, logic [4:0] act, logic [4:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got p/c/r/cause=%b want %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int edges;
    rst_n  = 1'b0;
    locked = 1'b0;
    sw_req = 1'b0;

    // power-up: 50 cycles without lock
    add(0, 0, 1, 1, 0, 2'b00, 50);
    // lock release: periph after edge 11, cpu/ready after edge 15
    add(1, 0, 1, 1, 0, 2'b00, 10);
    add(1, 0, 0, 1, 0, 2'b00, 4);
    add(1, 0, 0, 0, 1, 2'b00, 3);
    // lock loss in RUN: visible after edge 3
    add(0, 0, 0, 0, 1, 2'b00, 2);
    add(0, 0, 1, 1, 0, 2'b01, 3);
    // requalify with a 3-cycle glitch at STABLE cnt=5
    add(1, 0, 1, 1, 0, 2'b01, 8);
    add(0, 0, 1, 1, 0, 2'b01, 3);
    add(1, 0, 1, 1, 0, 2'b01, 10);
    add(1, 0, 0, 1, 0, 2'b01, 4);
    add(1, 0, 0, 0, 1, 2'b01, 2);
    // software reset, second request inside SW_RESET ignored
    add(1, 1, 1, 1, 0, 2'b10, 1);
    add(1, 0, 1, 1, 0, 2'b10, 1);
    add(1, 1, 1, 1, 0, 2'b10, 1);
    add(1, 0, 1, 1, 0, 2'b10, 3);
    add(1, 0, 0, 1, 0, 2'b10, 4);
    add(1, 0, 0, 0, 1, 2'b10, 3);
    // request on the edge lock_s first reads 0: lock loss wins
    add(0, 0, 0, 0, 1, 2'b10, 2);
    add(0, 1, 1, 1, 0, 2'b01, 1);
    add(0, 0, 1, 1, 0, 2'b01, 2);
    // requalify into PERIPH for the async reset abort
    add(1, 0, 1, 1, 0, 2'b01, 10);
    add(1, 0, 0, 1, 0, 2'b01, 2);

    repeat (3) @(posedge clk);
    #1;
    check("in_reset", {periph, cpu, ready, cause}, 5'b11000);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      locked = vq[i].lk;
      sw_req = vq[i].sw;
      tick();
      check($sformatf("vec%0d", i), {periph, cpu, ready, cause},
            {vq[i].p, vq[i].c, vq[i].r, vq[i].cs});
    end
    sw_req = 1'b0;

    // async reset in PERIPH takes effect without a clock edge
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_abort", {periph, cpu, ready, cause}, 5'b11000);
    tick();
    tick();
    check("held_reset", {periph, cpu, ready, cause}, 5'b11000);
    rst_n = 1'b1;

    // synchronizer was cleared: full release timing again
    edges = 0;
    while (periph && edges < 40) begin
      tick();
      edges++;
    end
    check("rerelease_periph_edge", 5'(edges), 5'd11);
    edges = 0;
    while (cpu && edges < 40) begin
      tick();
      edges++;
    end
    check("rerelease_cpu_delay", 5'(edges), 5'd4);
    check("rerelease_final", {periph, cpu, ready, cause}, 5'b00100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
